// File: rtl/rect_fill_pkg.sv
// Shared types and default geometry for the rectangle fill engine and its
// colour pattern generator.
package rect_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef enum logic [1:0] {
        SOLID      = 2'd0,
        COL_STRIPE = 2'd1,
        ROW_STRIPE = 2'd2,
        CHECKER    = 2'd3
    } fill_mode_e;

    localparam int unsigned DEF_SCREEN_W   = 160;
    localparam int unsigned DEF_SCREEN_H   = 120;
    localparam int unsigned DEF_X_W        = 8;
    localparam int unsigned DEF_Y_W        = 7;
    localparam int unsigned DEF_COLOUR_W   = 3;
    localparam int unsigned DEF_CHECK_LOG2 = 2;

endpackage

// File: rtl/rect_fill_colour.sv
// Combinational pattern generator: maps absolute pixel coordinates, the fill
// mode and the base colour to the colour written for that pixel.
module rect_fill_colour
    import rect_fill_pkg::*;
#(
    parameter int unsigned X_W        = DEF_X_W,
    parameter int unsigned Y_W        = DEF_Y_W,
    parameter int unsigned COLOUR_W   = DEF_COLOUR_W,
    parameter int unsigned CHECK_LOG2 = DEF_CHECK_LOG2
) (
    input  fill_mode_e          mode_i,
    input  logic [X_W:0]        ax_i,
    input  logic [Y_W:0]        ay_i,
    input  logic [COLOUR_W-1:0] colour_i,
    output logic [COLOUR_W-1:0] pixel_o
);

    // Sums are one bit wider than either operand so the slice above the
    // colour field always exists; only the low COLOUR_W bits matter (mod 2**COLOUR_W).
    localparam int unsigned XS = ((X_W + 1 > COLOUR_W) ? X_W + 1 : COLOUR_W) + 1;
    localparam int unsigned YS = ((Y_W + 1 > COLOUR_W) ? Y_W + 1 : COLOUR_W) + 1;

    logic [XS-1:0] xsum;
    logic [YS-1:0] ysum;
    logic          cell_odd;
    logic          unused_sum;

    always_comb begin
        xsum       = XS'(ax_i) + XS'(colour_i);
        ysum       = YS'(ay_i) + YS'(colour_i);
        cell_odd   = ax_i[CHECK_LOG2] ^ ay_i[CHECK_LOG2];
        unused_sum = ^{xsum[XS-1:COLOUR_W], ysum[YS-1:COLOUR_W]};
    end

    always_comb begin
        pixel_o = colour_i;
        case (mode_i)
            SOLID:      pixel_o = colour_i;
            COL_STRIPE: pixel_o = xsum[COLOUR_W-1:0];
            ROW_STRIPE: pixel_o = ysum[COLOUR_W-1:0];
            CHECKER:    pixel_o = cell_odd ? ~colour_i : colour_i;
            default:    pixel_o = colour_i;
        endcase
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: one pixel per clock, column-major scan, start/done
// handshake. Define RECT_FILL_CLIP_EN to suppress plots outside the screen.
module rect_fill_engine
    import rect_fill_pkg::*;
#(
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
    parameter int unsigned X_W        = DEF_X_W,
    parameter int unsigned Y_W        = DEF_Y_W,
    parameter int unsigned COLOUR_W   = DEF_COLOUR_W,
    parameter int unsigned CHECK_LOG2 = DEF_CHECK_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    fill_state_e         state_q;
    logic [X_W-1:0]      x0_q, w_q, dx_q, dx_d;
    logic [Y_W-1:0]      y0_q, h_q, dy_q, dy_d;
    fill_mode_e          mode_q, mode_sel;
    logic [COLOUR_W-1:0] colour_q, colour_sel, pix_colour;
    logic [X_W:0]        ax_d;
    logic [Y_W:0]        ay_d;
    logic                last_px, pix_on;

    logic                done_q, plot_q;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;

    // The coordinate of the pixel registered at the next edge comes straight
    // from the ports in IDLE so the first pixel appears one cycle after start.
    always_comb begin
        last_px = (dx_q == w_q - X_W'(1)) && (dy_q == h_q - Y_W'(1));
        dx_d    = dx_q;
        dy_d    = dy_q + Y_W'(1);
        if (dy_q == h_q - Y_W'(1)) begin
            dy_d = '0;
            dx_d = dx_q + X_W'(1);
        end
        if (state_q == IDLE) begin
            dx_d       = '0;
            dy_d       = '0;
            ax_d       = {1'b0, x0};
            ay_d       = {1'b0, y0};
            mode_sel   = fill_mode_e'(mode);
            colour_sel = colour;
        end else begin
            ax_d       = {1'b0, x0_q} + {1'b0, dx_d};
            ay_d       = {1'b0, y0_q} + {1'b0, dy_d};
            mode_sel   = mode_q;
            colour_sel = colour_q;
        end
    end

    always_comb begin
`ifdef RECT_FILL_CLIP_EN
        pix_on = (ax_d < (X_W + 1)'(SCREEN_W)) && (ay_d < (Y_W + 1)'(SCREEN_H));
`else
        pix_on = 1'b1;
`endif
    end

    rect_fill_colour #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .COLOUR_W   (COLOUR_W),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_colour (
        .mode_i   (mode_sel),
        .ax_i     (ax_d),
        .ay_i     (ay_d),
        .colour_i (colour_sel),
        .pixel_o  (pix_colour)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            mode_q       <= SOLID;
            colour_q     <= '0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        x0_q     <= x0;
                        y0_q     <= y0;
                        w_q      <= w;
                        h_q      <= h;
                        mode_q   <= fill_mode_e'(mode);
                        colour_q <= colour;
                        dx_q     <= '0;
                        dy_q     <= '0;
                        if (w == '0 || h == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= FILL;
                            vga_x_q      <= ax_d[X_W-1:0];
                            vga_y_q      <= ay_d[Y_W-1:0];
                            vga_colour_q <= pix_colour;
                            plot_q       <= pix_on;
                        end
                    end
                end
                FILL: begin
                    if (last_px) begin
                        state_q <= DONE;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        dx_q         <= dx_d;
                        dy_q         <= dy_d;
                        vga_x_q      <= ax_d[X_W-1:0];
                        vga_y_q      <= ay_d[Y_W-1:0];
                        vga_colour_q <= pix_colour;
                        plot_q       <= pix_on;
                    end
                end
                DONE: begin
                    plot_q <= 1'b0;
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    plot_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        done       = done_q;
        vga_plot   = plot_q;
        vga_x      = vga_x_q;
        vga_y      = vga_y_q;
        vga_colour = vga_colour_q;
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus randomized
// fills compared against an arithmetic reference of the expected pixel list.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x0, w;
    logic [6:0] y0, h;
    logic [1:0] mode;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    always #5 clk = ~clk;

    rect_fill_engine #(
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .X_W        (8),
        .Y_W        (7),
        .COLOUR_W   (3),
        .CHECK_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .mode       (mode),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   seen[int];
    int   n_plots, n_cycles, first_key, last_key;

    function automatic int key_of(int x, int y);
        return x * 256 + y;
    endfunction

    function automatic int ref_colour(int m, int ax, int ay, int c);
        case (m)
            0:       return c;
            1:       return (ax + c) % 8;
            2:       return (ay + c) % 8;
            default: return ((((ax >> 2) ^ (ay >> 2)) & 1) != 0) ? (~c) & 7 : c;
        endcase
    endfunction

    function automatic void build_expected(int xs, int ys, int wv, int hv, int mv, int cv);
        pix_t p;
        exp_q.delete();
        for (int dx = 0; dx < wv; dx++) begin
            for (int dy = 0; dy < hv; dy++) begin
                int ax = xs + dx;
                int ay = ys + dy;
`ifdef RECT_FILL_CLIP_EN
                if (ax >= 160 || ay >= 120) continue;
`endif
                p.x = ax % 256;
                p.y = ay % 128;
                p.c = ref_colour(mv, ax, ay, cv);
                exp_q.push_back(p);
            end
        end
    endfunction

    task automatic run_fill(input int xs, input int ys, input int wv, input int hv,
                            input int mv, input int cv);
        pix_t p;
        int   k;
        @(negedge clk);
        x0 = 8'(xs); y0 = 7'(ys); w = 8'(wv); h = 7'(hv);
        mode = 2'(mv); colour = 3'(cv);
        start = 1'b1;
        build_expected(xs, ys, wv, hv, mv, cv);
        n_plots = 0; n_cycles = 0; first_key = -1; last_key = -1;
        seen.delete();
        forever begin
            @(posedge clk); #1;
            n_cycles++;
            if (vga_plot) begin
                k = key_of(int'(vga_x), int'(vga_y));
                if (first_key < 0) first_key = k;
                last_key = k;
                seen[k] = int'(vga_colour);
                n_plots++;
                if (exp_q.size() == 0) chk("extra_plot", k, -1);
                else begin
                    p = exp_q.pop_front();
                    chk("pixel", (int'(vga_x) << 10) | (int'(vga_y) << 3) | int'(vga_colour),
                        (p.x << 10) | (p.y << 3) | p.c);
                end
            end
            if (done) break;
            if (n_cycles > wv * hv + 4) begin
                chk("done_timeout", n_cycles, wv * hv + 1);
                break;
            end
            // Inputs move after the latch; the engine must keep using the latched request.
            @(negedge clk);
            x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
            mode = 2'($urandom); colour = 3'($urandom);
        end
        chk("fill_cycles", n_cycles, wv * hv + 1);
        chk("missing_plots", exp_q.size(), 0);
        chk("plot_at_done", int'(vga_plot), 0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("done_held", int'(done), 1);
        chk("no_retrigger", int'(vga_plot), 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", int'(done), 0);
    endtask

    function automatic int seen_at(int x, int y);
        return seen.exists(key_of(x, y)) ? seen[key_of(x, y)] : -1;
    endfunction

    initial begin
        int quiet_plots;
        rst = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; mode = '0; colour = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        @(negedge clk);
        rst = 1'b0;

        run_fill(0, 0, 160, 120, 1, 0);
        chk("full_plots", n_plots, 19200);
        chk("full_px13_77", seen_at(13, 77), 5);
        chk("full_first", first_key, key_of(0, 0));
        chk("full_last", last_key, key_of(159, 119));

        run_fill(10, 20, 3, 2, 0, 6);
        chk("small_plots", n_plots, 6);
        chk("small_first", first_key, key_of(10, 20));
        chk("small_last", last_key, key_of(12, 21));
        chk("small_colour", seen_at(11, 21), 6);

        run_fill(30, 5, 0, 50, 0, 3);
        chk("zero_w_plots", n_plots, 0);
        run_fill(30, 5, 7, 0, 2, 3);
        chk("zero_h_plots", n_plots, 0);

        run_fill(0, 0, 8, 8, 3, 2);
        chk("chk_0_0", seen_at(0, 0), 2);
        chk("chk_4_0", seen_at(4, 0), 5);
        chk("chk_4_4", seen_at(4, 4), 2);
        chk("chk_3_7", seen_at(3, 7), 5);

        run_fill(158, 3, 4, 1, 0, 1);
`ifdef RECT_FILL_CLIP_EN
        chk("clip_plots", n_plots, 2);
        chk("clip_last", last_key, key_of(159, 3));
`else
        chk("wrap_plots", n_plots, 4);
        chk("wrap_last", last_key, key_of(161, 3));
`endif

        @(negedge clk);
        x0 = 8'd5; y0 = 7'd5; w = 8'd10; h = 7'd10; mode = 2'd0; colour = 3'd1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_fill_plot", int'(vga_plot), 1);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_plot", int'(vga_plot), 0);
        chk("rst_mid_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet_plots = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (vga_plot || done) quiet_plots++;
        end
        chk("rst_quiet", quiet_plots, 0);
        run_fill(5, 5, 10, 10, 0, 1);
        chk("restart_first", first_key, key_of(5, 5));
        chk("restart_plots", n_plots, 100);

        for (int i = 0; i < 25; i++) begin
            run_fill(int'($urandom_range(255)), int'($urandom_range(127)),
                     int'($urandom_range(12)), int'($urandom_range(12)),
                     int'($urandom_range(3)), int'($urandom_range(7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Parametrised successor of the lab fill-screen block.
- Fills an arbitrary rectangle (origin, width, height) at one pixel per clock, with a selectable colour pattern: solid, column stripes, row stripes or checkerboard.
- Sits between the top-level control FSM and the VGA adapter's x/y/colour/plot inputs.
- Uses a start/done handshake so the controller can chain multiple fills.

Parameters:
- SCREEN_W, 160, visible columns; clipping bound.
- SCREEN_H, 120, visible rows; clipping bound.
- X_W, 8, x coordinate / width field bits.
- Y_W, 7, y coordinate / height field bits.
- COLOUR_W, 3, colour bits.
- CHECK_LOG2, 2, checkerboard cell edge = 2**CHECK_LOG2 pixels.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a fill; level, held until done is seen.
- x0  in  X_W  rectangle left column.
- y0  in  Y_W  rectangle top row.
- w  in  X_W  rectangle width in pixels; 0 is legal.
- h  in  Y_W  rectangle height in pixels; 0 is legal.
- mode  in  2  0 SOLID, 1 COL_STRIPE, 2 ROW_STRIPE, 3 CHECKER.
- colour  in  COLOUR_W  base colour.
- done  out  1  fill complete; held while start remains high.
- vga_x  out  X_W  pixel column.
- vga_y  out  Y_W  pixel row.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write strobe for the current x/y/colour.

Behaviour:
- One clock domain; rst is synchronous and active-high.
- Reset values: state IDLE; done=0; vga_plot=0; vga_x=0; vga_y=0; vga_colour=0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - start=1 latches x0, y0, w, h, mode and colour.
  - If w==0 or h==0, go to DONE; otherwise clear dx/dy and go to FILL.
  - Input changes after the latch are ignored until the next IDLE.
- FILL:
  - Each cycle emits a registered pixel (x0+dx, y0+dy).
  - Scan order is column-major: dy is the inner loop (0..h-1), dx the outer loop (0..w-1).
  - The first pixel is visible on the outputs the cycle after start is sampled.
  - Exactly w*h FILL cycles; the last pixel is (x0+w-1, y0+h-1). Then go to DONE.
- DONE:
  - done=1 and vga_plot=0.
  - Stays in DONE while start=1.
  - start=0 returns to IDLE next cycle with done=0.
  - done rises the cycle after the last pixel.
- Pixel colour, using absolute coordinates ax=x0+dx and ay=y0+dy:
  - SOLID: colour.
  - COL_STRIPE: (ax + colour) mod 2**COLOUR_W. colour=0 reproduces the legacy x-mod-8 fill.
  - ROW_STRIPE: (ay + colour) mod 2**COLOUR_W.
  - CHECKER: colour when bit CHECK_LOG2 of ax XOR bit CHECK_LOG2 of ay is 0, else the bitwise complement of colour.
- Arithmetic: ax is computed in X_W+1 bits and ay in Y_W+1 bits; the carry bit is used for clipping.
- Reset mid-FILL or mid-DONE: next cycle is IDLE, vga_plot=0, done=0, no further pixels.
- start held high continuously: exactly one fill; no re-trigger until start has been low for at least one cycle.

Optional Feature:
- Macro RECT_FILL_CLIP_EN.
- Defined: pixels with ax>=SCREEN_W or ay>=SCREEN_H still consume their cycle but drive vga_plot=0. Cycle count stays w*h.
- Undefined: every FILL cycle plots; vga_x/vga_y are ax/ay truncated to X_W/Y_W bits, so they wrap modulo 2**X_W and 2**Y_W.

Decomposition:
- Package rect_fill_pkg:
  - Enum fill_state_e {IDLE, FILL, DONE}.
  - Enum fill_mode_e {SOLID, COL_STRIPE, ROW_STRIPE, CHECKER}.
  - Default screen constants.
- One sub-module, rect_fill_colour: purely combinational pattern generator (mode, ax, ay, colour -> pixel colour).
- FSM and dx/dy counters stay in rect_fill_engine.

Test Plan:
- Full screen, x0=0 y0=0 w=160 h=120 mode=COL_STRIPE colour=0 -> 19200 plot cycles; pixel (13,77) colour 5; first plot (0,0); last (159,119); done the next cycle.
- x0=10 y0=20 w=3 h=2 SOLID colour=6 -> plots (10,20),(10,21),(11,20),(11,21),(12,20),(12,21), all colour 6, then done=1; start dropped -> done=0 one cycle later.
- w=0 h=50 -> no vga_plot pulses; done=1 the cycle after start is sampled.
- CHECKER colour=2, x0=0 y0=0 w=8 h=8 -> (0,0)=2, (4,0)=5, (4,4)=2, (3,7)=5.
- RECT_FILL_CLIP_EN defined, x0=158 w=4 h=1 -> plots only (158,y0),(159,y0); done still after 4 FILL cycles. Undefined -> 4 plots, x = 158, 159, 160, 161.
- rst pulsed on the 5th FILL cycle of a 10x10 fill -> vga_plot=0 from the next cycle, done=0; a new start afterwards restarts from (x0,y0).
